// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and decode helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 4'b0001 : f3[1:0] == 2'b01 ? 4'b0011 : f3[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
              : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
endpackage

// File: rtl/lsu_misalign_if.sv
// lsu_misalign_if: core request/response and RAM port bundle of the load/store unit
interface lsu_misalign_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [3:0]        mem_wmask;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic [31:0]       mem_data_out;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_wmask, mem_address, mem_data_in
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_wmask, mem_address, mem_data_in
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane mask, write-data positioning and load extract/extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [7:0]  o_m8,
  output logic [63:0] o_d64,
  output logic [31:0] o_rdata
);
  logic [31:0] w_sh;

  assign o_m8  = {4'b0000, size_mask(i_funct3)} << i_off;
  assign o_d64 = {32'b0, i_wdata} << {i_off, 3'b000};
  assign w_sh  = 32'({i_hi, i_lo} >> {i_off, 3'b000});

  assign o_rdata = i_funct3 == F3_B  ? {{24{w_sh[7]}}, w_sh[7:0]}
                 : i_funct3 == F3_H  ? {{16{w_sh[15]}}, w_sh[15:0]}
                 : i_funct3 == F3_W  ? w_sh
                 : i_funct3 == F3_BU ? {24'b0, w_sh[7:0]}
                 : i_funct3 == F3_HU ? {16'b0, w_sh[15:0]}
                 : 32'b0;
endmodule

// File: rtl/lsu_misalign.sv
// lsu_misalign: splits RV32I loads/stores into one or two word-aligned byte-masked RAM beats
module lsu_misalign
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst_n,
  lsu_misalign_if.slave bus
);
  state_t            r_state, w_next;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_lo, r_hi;
  logic [7:0]        w_m8;
  logic [63:0]       w_d64;
  logic [31:0]       w_rdata;
  logic [ADDR_W-1:0] w_base;
  logic              w_legal, w_acc;

  assign w_acc   = bus.req_valid && r_state == IDLE;
  assign w_legal = is_legal(r_we, r_f3);
  assign w_base  = {r_addr[ADDR_W-1:2], 2'b00};

  lsu_align u_align (
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_f3),
    .i_wdata  (r_wdata),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_m8     (w_m8),
    .o_d64    (w_d64),
    .o_rdata  (w_rdata)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  // request capture at accept; RAM read words captured at the end of each beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b0;
      r_addr  <= '0;
      r_wdata <= 32'b0;
      r_lo    <= 32'b0;
      r_hi    <= 32'b0;
    end else begin
      if (w_acc) begin
        r_we    <= bus.req_we;
        r_f3    <= bus.req_funct3;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_hi    <= 32'b0;
      end
      if (r_state == BEAT0) r_lo <= bus.mem_data_out;
      if (r_state == BEAT1) r_hi <= bus.mem_data_out;
    end

  // next state and all outputs; RAM side decodes only from state and registered request
  always_comb begin
    w_next          = r_state;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_rdata  = 32'b0;
    bus.resp_err    = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_wmask   = 4'b0;
    bus.mem_address = '0;
    bus.mem_data_in = 32'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = is_legal(bus.req_we, bus.req_funct3) ? BEAT0 : DONE;
      end
      BEAT0: begin
        bus.mem_we      = r_we;
        bus.mem_wmask   = w_m8[3:0];
        bus.mem_address = w_base;
        bus.mem_data_in = w_d64[31:0];
        w_next          = |w_m8[7:4] ? BEAT1 : DONE;
      end
      BEAT1: begin
        bus.mem_we      = r_we;
        bus.mem_wmask   = w_m8[7:4];
        bus.mem_address = w_base + ADDR_W'(4);
        bus.mem_data_in = w_d64[63:32];
        w_next          = DONE;
      end
      default: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = !w_legal;
        bus.resp_rdata = (!r_we && w_legal) ? w_rdata : 32'b0;
        w_next         = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_lsu_misalign.sv
// tb_lsu_misalign: byte-level model of the LSU and RAM checked against the DUT every cycle
module tb_lsu_misalign;
  import lsu_pkg::*;

  typedef struct packed {
    logic        ready;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;
  cyc_t q[$];
  int t_cyc = 0;
  logic [31:0] obs_addr [8];
  logic [3:0]  obs_mask [8];
  logic [31:0] obs_data [8];
  int resp_at = -1;
  logic [31:0] resp_rdata = 32'b0;
  logic resp_err = 1'b0;
  logic [31:0] ram [8] = '{default: 32'b0};
  logic [7:0]  mdl [32] = '{default: 8'b0};

  lsu_misalign_if #(.ADDR_W(32)) bus ();

  lsu_misalign #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_data_out = ram[bus.mem_address[4:2]];

  always @(posedge clk)
    if (bus.mem_we)
      for (int l = 0; l < 4; l++)
        if (bus.mem_wmask[l]) ram[bus.mem_address[4:2]][8*l +: 8] <= bus.mem_data_in[8*l +: 8];

  always @(negedge clk) begin
    cyc_t g, e;
    if (chk_en) begin
      g = '{bus.req_ready, bus.mem_we, bus.mem_wmask, bus.mem_address, bus.mem_data_in,
            bus.resp_valid, bus.resp_rdata, bus.resp_err};
      e = '0;
      e.ready = 1'b1;
      if (q.size() > 0) e = q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got rdy=%b we=%b m=%h a=%h d=%h rv=%b rd=%h err=%b, need rdy=%b we=%b m=%h a=%h d=%h rv=%b rd=%h err=%b",
                 $time, g.ready, g.we, g.mask, g.addr, g.data, g.rv, g.rdata, g.err,
                 e.ready, e.we, e.mask, e.addr, e.data, e.rv, e.rdata, e.err);
      end
      if (t_cyc < 8) begin
        obs_addr[t_cyc] = g.addr;
        obs_mask[t_cyc] = g.mask;
        obs_data[t_cyc] = g.data;
      end
      if (g.rv) begin
        resp_at    = t_cyc;
        resp_rdata = g.rdata;
        resp_err   = g.err;
      end
      t_cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, need %h", name, got, exp);
    end
  endtask

  task automatic model_push(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    cyc_t e;
    int sz, off, nb, pos;
    logic [31:0] v;
    logic legal;
    legal = we ? (f3 inside {3'b000, 3'b001, 3'b010}) : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (legal) begin
      sz  = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
      off = int'(a[1:0]);
      nb  = off + sz > 4 ? 2 : 1;
      for (int b = 0; b < nb; b++) begin
        e = '0;
        e.we   = we;
        e.addr = {a[31:2], 2'b00} + 32'(4 * b);
        for (int l = 0; l < 4; l++) begin
          pos = 4 * b + l - off;
          if (pos >= 0 && pos < 4) e.data[8*l +: 8] = wd[8*pos +: 8];
          if (pos >= 0 && pos < sz) e.mask[l] = 1'b1;
        end
        q.push_back(e);
      end
      v = 32'b0;
      for (int i = 0; i < sz; i++) begin
        if (we) mdl[(a + 32'(i)) & 32'd31] = wd[8*i +: 8];
        else    v[8*i +: 8] = mdl[(a + 32'(i)) & 32'd31];
      end
      if (!we && !f3[2] && sz < 4 && v[8*sz-1])
        for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end else v = 32'b0;
    e = '0;
    e.rv    = 1'b1;
    e.err   = !legal;
    e.rdata = v;
    q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hDEAD_BEE1;
    bus.req_wdata  = 32'hA5A5_5A5A;
    t_cyc   = 1;
    resp_at = -1;
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    issue(we, f3, a, wd);
    model_push(we, f3, a, wd);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected cycles left unchecked", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen_rv;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b0;
    bus.req_addr   = 32'b0;
    bus.req_wdata  = 32'b0;
    #3;
    chk("reset ready", {31'b0, bus.req_ready}, 32'd1);
    chk("reset outs", {bus.mem_we, bus.mem_wmask, bus.resp_valid, bus.resp_err}, 32'd0);
    chk("reset addr", bus.mem_address, 32'd0);
    chk("reset rdata", bus.resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run(1'b1, F3_W, 32'h0, 32'h1234_5678);
    chk("sw0 addr", obs_addr[1], 32'h0);
    chk("sw0 mask", {28'b0, obs_mask[1]}, 32'hF);
    chk("sw0 data", obs_data[1], 32'h1234_5678);
    chk("sw0 latency", resp_at, 2);

    run(1'b1, F3_B, 32'h1, 32'h0000_0078);
    chk("sb1 mask", {28'b0, obs_mask[1]}, 32'h2);
    chk("sb1 data", obs_data[1], 32'h0000_7800);
    run(1'b1, F3_H, 32'h5, 32'h0000_BEEF);
    chk("sh5 addr", obs_addr[1], 32'h4);
    chk("sh5 mask", {28'b0, obs_mask[1]}, 32'h6);
    chk("sh5 data", obs_data[1], 32'h00BE_EF00);

    run(1'b1, F3_W, 32'h6, 32'h1234_5678);
    chk("sw6 b0 addr", obs_addr[1], 32'h4);
    chk("sw6 b0 mask", {28'b0, obs_mask[1]}, 32'hC);
    chk("sw6 b0 data", obs_data[1], 32'h5678_0000);
    chk("sw6 b1 addr", obs_addr[2], 32'h8);
    chk("sw6 b1 mask", {28'b0, obs_mask[2]}, 32'h3);
    chk("sw6 b1 data", obs_data[2], 32'h0000_1234);
    run(1'b0, F3_W, 32'h6, 32'h0);
    chk("lw6 rdata", resp_rdata, 32'h1234_5678);
    chk("lw6 latency", resp_at, 3);

    run(1'b1, F3_W, 32'h0, 32'h80FF_0000);
    run(1'b0, F3_B, 32'h3, 32'h0);
    chk("lb3", resp_rdata, 32'hFFFF_FF80);
    run(1'b0, F3_BU, 32'h3, 32'h0);
    chk("lbu3", resp_rdata, 32'h0000_0080);
    run(1'b0, F3_H, 32'h2, 32'h0);
    chk("lh2", resp_rdata, 32'hFFFF_80FF);
    run(1'b0, F3_HU, 32'h2, 32'h0);
    chk("lhu2", resp_rdata, 32'h0000_80FF);

    run(1'b1, F3_H, 32'h3, 32'h0000_CAFE);
    run(1'b0, F3_H, 32'h3, 32'h0);
    chk("lh3 cross", resp_rdata, 32'hFFFF_CAFE);
    run(1'b0, F3_HU, 32'h3, 32'h0);
    chk("lhu3 cross", resp_rdata, 32'h0000_CAFE);

    run(1'b1, F3_W, 32'hFFFF_FFFE, 32'hDEAD_BEEF);
    run(1'b0, F3_W, 32'hFFFF_FFFE, 32'h0);
    chk("wrap b0 addr", obs_addr[1], 32'hFFFF_FFFC);
    chk("wrap b1 addr", obs_addr[2], 32'h0000_0000);
    chk("wrap rdata", resp_rdata, 32'hDEAD_BEEF);

    run(1'b0, 3'b011, 32'h4, 32'h0);
    chk("ill ld err", {31'b0, resp_err}, 32'd1);
    chk("ill ld rdata", resp_rdata, 32'h0);
    chk("ill ld latency", resp_at, 1);
    run(1'b1, 3'b100, 32'h8, 32'hFFFF_FFFF);
    chk("ill st err", {31'b0, resp_err}, 32'd1);

    run(1'b1, F3_W, 32'h4, 32'h0);
    run(1'b1, F3_W, 32'h8, 32'h0);
    chk_en = 1'b0;
    issue(1'b1, F3_W, 32'h6, 32'h1234_5678);
    @(posedge clk);
    #2;
    chk("rst pre we", {31'b0, bus.mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst we drop", {31'b0, bus.mem_we}, 32'd0);
    chk("rst ready", {31'b0, bus.req_ready}, 32'd1);
    seen_rv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_rv = seen_rv | bus.resp_valid;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen_rv = seen_rv | bus.resp_valid;
    end
    chk("rst no resp", {31'b0, seen_rv}, 32'd0);
    chk("rst ram w1", ram[1], 32'h5678_0000);
    chk("rst ram w2", ram[2], 32'h0000_0000);
    mdl[6] = 8'h78;
    mdl[7] = 8'h56;
    chk_en = 1'b1;
    run(1'b0, F3_W, 32'h6, 32'h0);
    chk("post rst lw6", resp_rdata, 32'h0000_5678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
